// File: rtl/melody_sequencer.sv
// Melody table walker: fetches {dur, div} entries from a synchronous ROM and drives
// note_div/sound for the speaker path with tempo scaling, gaps, pause, stop and looping.
module melody_sequencer #(
  parameter int unsigned ADDR_W     = 6,
  parameter int unsigned BEAT_TICKS = 4000000,
  parameter int unsigned GAP_TICKS  = 400000,
  parameter logic [15:0] AMPLITUDE  = 16'h3FFF,
  parameter logic [19:0] IDLE_DIV   = 20'd100000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              play,
  input  logic              stop,
  input  logic              loop_en,
  input  logic [1:0]        tempo_sel,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [22:0]       rom_data,
  output logic [19:0]       note_div,
  output logic [15:0]       sound,
  output logic              busy,
  output logic              done
);

  localparam int unsigned NOTE_W = $clog2(7 * BEAT_TICKS + 1);
  localparam int unsigned GAP_W  = $clog2(GAP_TICKS + 1);
  localparam int unsigned CW     = (NOTE_W > GAP_W) ? NOTE_W : GAP_W;
  localparam logic [CW-1:0] BEAT   = CW'(BEAT_TICKS);
  localparam logic [CW-1:0] GAP_LD = (GAP_TICKS == 0) ? '0 : CW'(GAP_TICKS - 1);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_NOTE, S_GAP} state_t;

  state_t            state_q, state_d;
  logic              fetch2_q, fetch2_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [19:0]       div_q, div_d;
  logic [15:0]       amp_q, amp_d;
  logic [15:0]       sound_q, sound_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              play_q;

  logic [2:0]        dur;
  logic [19:0]       div;
  logic [CW-1:0]     note_len;
  logic              eos, eos_marker, advance;

  assign dur      = rom_data[22:20];
  assign div      = rom_data[19:0];
  assign note_len = CW'(dur) * (BEAT >> tempo_sel);

  always_comb begin
    state_d    = state_q;
    fetch2_d   = fetch2_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    div_d      = div_q;
    amp_d      = amp_q;
    sound_d    = '0;
    done_d     = 1'b0;
    eos        = 1'b0;
    eos_marker = 1'b0;
    advance    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (play && !play_q) begin
          state_d  = S_FETCH;
          fetch2_d = 1'b0;
        end
      end
      S_FETCH: begin
        if (!fetch2_q) begin
          fetch2_d = 1'b1;
        end else if (dur == 3'd0) begin
          eos        = 1'b1;
          eos_marker = 1'b1;
        end else begin
          state_d = S_NOTE;
          cnt_d   = note_len - CW'(1);
          if (div != 20'd0) begin
            div_d   = div;
            amp_d   = AMPLITUDE;
            sound_d = AMPLITUDE;
          end else begin
            amp_d = '0;
          end
        end
      end
      S_NOTE: begin
        // play low freezes the count and mutes without leaving the state
        if (play) begin
          if (cnt_q == '0) begin
            if (GAP_TICKS == 0) begin
              advance = 1'b1;
            end else begin
              state_d = S_GAP;
              cnt_d   = GAP_LD;
            end
          end else begin
            cnt_d   = cnt_q - CW'(1);
            sound_d = amp_q;
          end
        end
      end
      S_GAP: begin
        if (play) begin
          if (cnt_q == '0) advance = 1'b1;
          else             cnt_d   = cnt_q - CW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (advance) begin
      if (addr_q == '1) begin
        eos = 1'b1;
      end else begin
        addr_d   = addr_q + ADDR_W'(1);
        state_d  = S_FETCH;
        fetch2_d = 1'b0;
      end
    end

    // an end marker at entry 0 would loop forever, so it always ends the song
    if (eos) begin
      addr_d = '0;
      if (loop_en && !(eos_marker && addr_q == '0)) begin
        state_d  = S_FETCH;
        fetch2_d = 1'b0;
      end else begin
        state_d = S_IDLE;
        done_d  = 1'b1;
      end
    end

    if (stop) begin
      state_d = S_IDLE;
      addr_d  = '0;
      cnt_d   = '0;
      sound_d = '0;
      done_d  = 1'b0;
    end

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      fetch2_q <= 1'b0;
      cnt_q    <= '0;
      addr_q   <= '0;
      div_q    <= IDLE_DIV;
      amp_q    <= '0;
      sound_q  <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      play_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      fetch2_q <= fetch2_d;
      cnt_q    <= cnt_d;
      addr_q   <= addr_d;
      div_q    <= div_d;
      amp_q    <= amp_d;
      sound_q  <= sound_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      play_q   <= play;
    end
  end

  assign rom_addr = addr_q;
  assign note_div = div_q;
  assign sound    = sound_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule
